// File: rtl/rr_arb_mux_if.sv
// Valid/ready bundle for rr_arb_mux: CH request channels in, one
// registered word out.
interface rr_arb_mux_if #(
    parameter int WIDTH = 8,
    parameter int CH    = 4
) ();
    localparam int SW = $clog2(CH);

    logic [CH-1:0]       in_valid;
    logic [CH-1:0]       in_ready;
    logic [CH*WIDTH-1:0] in_data;
    logic                out_valid;
    logic                out_ready;
    logic [WIDTH-1:0]    out_data;
    logic [SW-1:0]       out_sel;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );
endinterface

// File: rtl/rr_arb_mux.sv
// N-channel arbitrated mux: round-robin or fixed-priority grant feeding
// a single registered valid/ready output slot.
module rr_arb_mux #(
    parameter int WIDTH = 8,
    parameter int CH    = 4,
    parameter int MODE  = 0,
    parameter int SW    = $clog2(CH)
) (
    input  logic         clk,
    input  logic         rst_n,
    rr_arb_mux_if.slave  bus
);
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SW-1:0]    out_sel_q, out_sel_d;
    logic [SW-1:0]    ptr_q, ptr_d;

    logic             free;
    logic             found;
    logic             grant_en;
    logic [SW-1:0]    g;
    logic [CH-1:0]    grant;
    int               start;
    int               idx;

    // Circular search from the pointer; fixed mode always starts at 0.
    always_comb begin
        free  = !out_valid_q || bus.out_ready;
        found = 1'b0;
        g     = '0;
        idx   = 0;
        start = (MODE == 1) ? 0 : int'(ptr_q);
        for (int k = 0; k < CH; k++) begin
            idx = start + k;
            if (idx >= CH) idx = idx - CH;
            if (!found && bus.in_valid[SW'(idx)]) begin
                found = 1'b1;
                g     = SW'(idx);
            end
        end
        grant_en = free && found && rst_n;
    end

    always_comb begin
        grant = '0;
        if (grant_en) grant[g] = 1'b1;
    end

    assign bus.in_ready = grant;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
        if (grant_en) begin
            out_valid_d = 1'b1;
            out_data_d  = bus.in_data[g*WIDTH +: WIDTH];
            out_sel_d   = g;
            if (MODE == 0) begin
                ptr_d = (g == SW'(CH - 1)) ? '0 : g + SW'(1);
            end
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;
endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux: round-robin instance and a
// fixed-priority instance sharing clock and reset.
module tb_rr_arb_mux;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    rr_arb_mux_if #(.WIDTH(8), .CH(4)) b0 ();
    rr_arb_mux_if #(.WIDTH(8), .CH(4)) b1 ();

    rr_arb_mux #(.WIDTH(8), .CH(4), .MODE(0)) u0 (
        .clk(clk), .rst_n(rst_n), .bus(b0.slave)
    );
    rr_arb_mux #(.WIDTH(8), .CH(4), .MODE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(b1.slave)
    );

    task automatic test_reset();
        rst_n = 1'b0;
        b0.in_valid  = 4'b1111;
        b0.in_data   = 32'h44332211;
        b0.out_ready = 1'b1;
        b1.in_valid  = 4'b0000;
        b1.in_data   = 32'h44332211;
        b1.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (b0.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b expected 0", b0.out_valid);
        end
        checks++;
        if (b0.out_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_data: got %h expected 00", b0.out_data);
        end
        checks++;
        if (b0.out_sel !== 2'd0) begin
            errors++;
            $display("FAIL reset_sel: got %0d expected 0", b0.out_sel);
        end
        checks++;
        if (b0.in_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 0000", b0.in_ready);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (b0.in_ready !== 4'b0001) begin
            errors++;
            $display("FAIL release_ready: got %b expected 0001", b0.in_ready);
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_d [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
        logic [1:0] exp_s [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (b0.out_valid !== 1'b1 || b0.out_data !== exp_d[i] ||
                b0.out_sel !== exp_s[i]) begin
                errors++;
                $display("FAIL rr_word%0d: got v=%b d=%h s=%0d expected v=1 d=%h s=%0d",
                         i, b0.out_valid, b0.out_data, b0.out_sel,
                         exp_d[i], exp_s[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        b0.out_ready = 1'b0;
        #1;
        checks++;
        if (b0.in_ready !== 4'b0000) begin
            errors++;
            $display("FAIL bp_ready: got %b expected 0000", b0.in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (b0.out_valid !== 1'b1 || b0.out_data !== 8'h11 ||
                b0.out_sel !== 2'd0 || b0.in_ready !== 4'b0000) begin
                errors++;
                $display("FAIL bp_hold%0d: got v=%b d=%h s=%0d r=%b expected v=1 d=11 s=0 r=0000",
                         i, b0.out_valid, b0.out_data, b0.out_sel, b0.in_ready);
            end
        end
        b0.out_ready = 1'b1;
        #1;
        checks++;
        if (b0.in_ready !== 4'b0010) begin
            errors++;
            $display("FAIL bp_release_ready: got %b expected 0010", b0.in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (b0.out_valid !== 1'b1 || b0.out_data !== 8'h22 ||
            b0.out_sel !== 2'd1) begin
            errors++;
            $display("FAIL bp_next: got v=%b d=%h s=%0d expected v=1 d=22 s=1",
                     b0.out_valid, b0.out_data, b0.out_sel);
        end
        b0.in_valid = 4'b0000;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (b0.out_valid !== 1'b0 || b0.out_data !== 8'h22 ||
            b0.out_sel !== 2'd1) begin
            errors++;
            $display("FAIL drain: got v=%b d=%h s=%0d expected v=0 d=22 s=1",
                     b0.out_valid, b0.out_data, b0.out_sel);
        end
    endtask

    task automatic test_ptr_wrap();
        b0.in_valid = 4'b1010;
        #1;
        checks++;
        if (b0.in_ready !== 4'b1000) begin
            errors++;
            $display("FAIL wrap_ready3: got %b expected 1000", b0.in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (b0.out_data !== 8'h44 || b0.out_sel !== 2'd3) begin
            errors++;
            $display("FAIL wrap_word3: got d=%h s=%0d expected d=44 s=3",
                     b0.out_data, b0.out_sel);
        end
        b0.in_valid = 4'b0010;
        #1;
        checks++;
        if (b0.in_ready !== 4'b0010) begin
            errors++;
            $display("FAIL wrap_ready1: got %b expected 0010", b0.in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (b0.out_data !== 8'h22 || b0.out_sel !== 2'd1) begin
            errors++;
            $display("FAIL wrap_word1: got d=%h s=%0d expected d=22 s=1",
                     b0.out_data, b0.out_sel);
        end
        b0.in_valid = 4'b1111;
        #1;
        checks++;
        if (b0.in_ready !== 4'b0100) begin
            errors++;
            $display("FAIL wrap_ptr2: got %b expected 0100", b0.in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (b0.out_data !== 8'h33 || b0.out_sel !== 2'd2) begin
            errors++;
            $display("FAIL wrap_word2: got d=%h s=%0d expected d=33 s=2",
                     b0.out_data, b0.out_sel);
        end
        b0.in_valid = 4'b0000;
    endtask

    task automatic test_fixed();
        b1.in_valid = 4'b1111;
        #1;
        checks++;
        if (b1.in_ready !== 4'b0001) begin
            errors++;
            $display("FAIL fix_ready0: got %b expected 0001", b1.in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (b1.out_valid !== 1'b1 || b1.out_data !== 8'h11 ||
                b1.out_sel !== 2'd0) begin
                errors++;
                $display("FAIL fix_word%0d: got v=%b d=%h s=%0d expected v=1 d=11 s=0",
                         i, b1.out_valid, b1.out_data, b1.out_sel);
            end
        end
        b1.in_valid = 4'b1110;
        #1;
        checks++;
        if (b1.in_ready !== 4'b0010) begin
            errors++;
            $display("FAIL fix_ready1: got %b expected 0010", b1.in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (b1.out_data !== 8'h22 || b1.out_sel !== 2'd1) begin
            errors++;
            $display("FAIL fix_word1: got d=%h s=%0d expected d=22 s=1",
                     b1.out_data, b1.out_sel);
        end
        b1.in_valid = 4'b0000;
    endtask

    task automatic test_mid_reset();
        b0.in_data  = 32'h443322A5;
        b0.in_valid = 4'b0001;
        @(posedge clk);
        @(negedge clk);
        b0.in_valid  = 4'b0000;
        b0.out_ready = 1'b0;
        checks++;
        if (b0.out_valid !== 1'b1 || b0.out_data !== 8'hA5) begin
            errors++;
            $display("FAIL mid_hold: got v=%b d=%h expected v=1 d=a5",
                     b0.out_valid, b0.out_data);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (b0.out_valid !== 1'b0 || b0.out_data !== 8'h00 ||
            b0.out_sel !== 2'd0) begin
            errors++;
            $display("FAIL mid_reset: got v=%b d=%h s=%0d expected v=0 d=00 s=0",
                     b0.out_valid, b0.out_data, b0.out_sel);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_backpressure();
        test_ptr_wrap();
        test_fixed();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rr_arb_mux.md
# rr_arb_mux

Parametrised N-channel, W-bit arbitrated multiplexer with a registered output stage. It is the successor to the team's fixed 8-bit 2:1 mux. Instead of a static select, it grants one of CH valid/ready input channels per cycle under a round-robin or fixed-priority policy and forwards the granted word to a single valid/ready output. It sits between multiple producers and one shared consumer.

## Interface
- WIDTH, 8, data width in bits (1..64)
- CH, 4, number of input channels (2..8)
- MODE, 0, arbitration policy: 0 = round-robin, 1 = fixed priority (lowest index wins)
- SW, $clog2(CH), derived select width; not overridden
- clk  input  1  single clock, all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  CH  per-channel request; bit i belongs to channel i
- in_ready  output  CH  per-channel accept; at most one bit high per cycle
- in_data  input  CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- out_valid  output  1  output register holds a word
- out_ready  input  1  consumer accepts the word
- out_data  output  WIDTH  registered winning word
- out_sel  output  SW  index of the channel that supplied out_data

## Operation
- Output slot is free when out_valid==0 or out_ready==1. Define free = !out_valid | out_ready.
- Grant is combinational, one-hot or zero:
  - When free==1 and any in_valid is set, exactly one channel g is granted, and in_ready[g]=1.
  - When free==0, in_ready is all zeros.
- A transfer on input channel i occurs when in_valid[i] & in_ready[i].
- Round-robin (MODE=0):
  - Pointer ptr has range 0..CH-1.
  - g is the first requesting index searching ptr, ptr+1, …, CH-1, 0, …, ptr-1.
  - On a transfer, ptr <= (g+1) mod CH, wrapping CH-1 -> 0.
  - With no transfer, ptr holds.
- Fixed (MODE=1): g is the lowest requesting index. ptr is held at 0 and unused.
- Output register update on each clock edge:
  - Input transfer: out_data <= in_data[g], out_sel <= g, out_valid <= 1.
  - Else if out_ready: out_valid <= 0. out_data and out_sel hold their last values.
  - Else: hold.
- Simultaneous output handoff and new input grant in the same cycle is allowed. It yields back-to-back words with no bubble.
- Data is passed unmodified. There is no width conversion.
- Protocol assumptions on sources and consumer:
  - A source keeps in_valid and in_data stable until its transfer completes.
  - in_valid must not depend combinationally on in_ready.
  - The consumer may toggle out_ready freely.

## Timing
- Reset (rst_n low, asynchronous) sets out_valid=0, out_data=0, out_sel=0, ptr=0. in_ready is then all zeros because the grant is gated by reset.
- Reset asserted mid-operation discards any held word immediately, with no handshake.
- First grant is possible in the first cycle with rst_n high.
- Latency: 1 cycle from input transfer edge to out_valid high with the word.
- Throughput: 1 word/cycle while out_ready stays high.
- Combinational paths:
  - out_ready -> in_ready.
  - in_valid -> in_ready.
  - There is no path from in_data to any output other than through the register.
- Backpressure: with out_valid=1 and out_ready=0, all in_ready=0 and out_data/out_sel are stable.
- No requests: in_ready=0, and out_valid drains to 0 one edge after out_ready.
- Single requester under round-robin: it is granted every free cycle, and ptr advances past it each time.

## Test plan
- Reset: rst_n=0 with all in_valid=1 -> out_valid=0, out_data=0x00, out_sel=0, in_ready=0000. Release -> grant goes to ch0 first.
- Round-robin fairness: WIDTH=8, CH=4, MODE=0. in_data = {0x44,0x33,0x22,0x11}, all in_valid=1, out_ready=1 held -> out_data sequence 0x11,0x22,0x33,0x44,0x11, with out_sel 0,1,2,3,0 on consecutive cycles.
- Backpressure: hold out_ready=0 for 3 cycles after the first word -> out_data stays 0x11 and out_sel stays 0, with in_ready=0000. Release -> next word 0x22 the following cycle, none lost or duplicated.
- Pointer wrap with sparse requests: only ch3 and ch1 valid, ptr=2 -> ch3 granted, then ch1. ptr ends at 2.
- Fixed priority: MODE=1, all valid, out_ready=1 -> ch0 (0x11) granted every cycle. Drop in_valid[0] -> ch1 (0x22) granted next.
- Mid-operation reset: out_valid=1 holding 0xA5, pulse rst_n low between edges -> out_valid and out_data go to 0 immediately, with no clock needed.
